// File: rtl/cpu_core_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cpu_core_hs
// Brief    : Parametrised multi-cycle CPU with a ready/valid memory handshake.
//            Holds control FSM, register file, decode, ALU and PC. It talks to
//            one unified instruction/data memory that may stall any access.
//            Optional build macro CPU_SIGNED_BRANCH_EN makes the branch offset
//            sign-extended; without it the offset is zero-extended.
// Revision : 1.0 - initial release
// ============================================================================
// Opcode map (zero-extended opcode value):
//   0 ADD  1 SUB  2 AND  3 OR   4 XOR  5 NOT  6 SHL  7 SHR
//   8 ADDI 9 MV  10 LUI 11 LI  12 LOAD 13 STORE 14 BEQ 15 HALT
//  16 ANDI 17 BNE  (reachable only when OPCODE_SIZE >= 5)
// Any other value executes as a NOP. OPCODE_SIZE must not exceed 8, and
// MEM_ADDR_SIZE must be wider than IMM_SIZE for branch offsets.
module cpu_core_hs #(
    parameter int WORD_SIZE     = 16,
    parameter int OPCODE_SIZE   = 4,
    parameter int REG_ADDR_SIZE = 4,
    parameter int IMM_SIZE      = 8,
    parameter int MEM_ADDR_SIZE = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     execute,
    output logic                     halted,
    output logic [MEM_ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic                     mem_ready,
    input  logic [WORD_SIZE-1:0]     mem_read_data,
    output logic [3:0]               state,
    output logic [OPCODE_SIZE-1:0]   opcode
);

    localparam int c_NREGS = 2 ** REG_ADDR_SIZE;

    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_FETCH  = 4'd1;
    localparam logic [3:0] c_ST_DECODE = 4'd2;
    localparam logic [3:0] c_ST_EXEC   = 4'd3;
    localparam logic [3:0] c_ST_MEM    = 4'd4;
    localparam logic [3:0] c_ST_WB     = 4'd5;
    localparam logic [3:0] c_ST_NEXT   = 4'd6;
    localparam logic [3:0] c_ST_HALT   = 4'd7;

    localparam logic [7:0] c_OP_ADD   = 8'd0;
    localparam logic [7:0] c_OP_SUB   = 8'd1;
    localparam logic [7:0] c_OP_AND   = 8'd2;
    localparam logic [7:0] c_OP_OR    = 8'd3;
    localparam logic [7:0] c_OP_XOR   = 8'd4;
    localparam logic [7:0] c_OP_NOT   = 8'd5;
    localparam logic [7:0] c_OP_SHL   = 8'd6;
    localparam logic [7:0] c_OP_SHR   = 8'd7;
    localparam logic [7:0] c_OP_ADDI  = 8'd8;
    localparam logic [7:0] c_OP_MV    = 8'd9;
    localparam logic [7:0] c_OP_LUI   = 8'd10;
    localparam logic [7:0] c_OP_LI    = 8'd11;
    localparam logic [7:0] c_OP_LOAD  = 8'd12;
    localparam logic [7:0] c_OP_STORE = 8'd13;
    localparam logic [7:0] c_OP_BEQ   = 8'd14;
    localparam logic [7:0] c_OP_HALT  = 8'd15;
    localparam logic [7:0] c_OP_ANDI  = 8'd16;
    localparam logic [7:0] c_OP_BNE   = 8'd17;

    logic [3:0]               state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0]     ir_q;
    logic [WORD_SIZE-1:0]     rd_val_q, rs_val_q, result_q;
    logic                     take_q;
    logic [WORD_SIZE-1:0]     regs_q [c_NREGS];

    // Instruction fields of the latched instruction
    logic [OPCODE_SIZE-1:0]   w_op;
    logic [7:0]               w_op_x;
    logic [REG_ADDR_SIZE-1:0] w_rd, w_rs;
    logic [IMM_SIZE-1:0]      w_imm;
    logic [WORD_SIZE-1:0]     w_imm_zx;
    logic [MEM_ADDR_SIZE-1:0] w_off;
    logic [WORD_SIZE-1:0]     w_alu;
    logic                     w_take;
    logic                     w_writes_rd;

    assign w_op     = ir_q[WORD_SIZE-1 -: OPCODE_SIZE];
    assign w_op_x   = 8'(w_op);
    assign w_rd     = ir_q[WORD_SIZE-OPCODE_SIZE-1 -: REG_ADDR_SIZE];
    assign w_rs     = ir_q[WORD_SIZE-OPCODE_SIZE-REG_ADDR_SIZE-1 -: REG_ADDR_SIZE];
    assign w_imm    = ir_q[IMM_SIZE-1:0];
    assign w_imm_zx = WORD_SIZE'(w_imm);

`ifdef CPU_SIGNED_BRANCH_EN
    assign w_off = MEM_ADDR_SIZE'($signed(w_imm));
`else
    assign w_off = MEM_ADDR_SIZE'(w_imm);
`endif

    // ALU result, branch decision and write-back enable for the latched op
    always_comb begin
        w_alu       = rd_val_q;
        w_take      = 1'b0;
        w_writes_rd = 1'b0;
        case (w_op_x)
            c_OP_ADD:   begin w_alu = rd_val_q + rs_val_q;         w_writes_rd = 1'b1; end
            c_OP_SUB:   begin w_alu = rd_val_q - rs_val_q;         w_writes_rd = 1'b1; end
            c_OP_AND:   begin w_alu = rd_val_q & rs_val_q;         w_writes_rd = 1'b1; end
            c_OP_OR:    begin w_alu = rd_val_q | rs_val_q;         w_writes_rd = 1'b1; end
            c_OP_XOR:   begin w_alu = rd_val_q ^ rs_val_q;         w_writes_rd = 1'b1; end
            c_OP_NOT:   begin w_alu = ~rd_val_q;                   w_writes_rd = 1'b1; end
            c_OP_SHL:   begin w_alu = rd_val_q << rs_val_q[3:0];   w_writes_rd = 1'b1; end
            c_OP_SHR:   begin w_alu = rd_val_q >> rs_val_q[3:0];   w_writes_rd = 1'b1; end
            c_OP_ADDI:  begin w_alu = rd_val_q + w_imm_zx;         w_writes_rd = 1'b1; end
            c_OP_ANDI:  begin w_alu = rd_val_q & w_imm_zx;         w_writes_rd = 1'b1; end
            c_OP_MV:    begin w_alu = rs_val_q;                    w_writes_rd = 1'b1; end
            c_OP_LUI:   begin w_alu = {w_imm, {(WORD_SIZE-IMM_SIZE){1'b0}}}; w_writes_rd = 1'b1; end
            c_OP_LI:    begin w_alu = {rd_val_q[WORD_SIZE-1:IMM_SIZE], w_imm}; w_writes_rd = 1'b1; end
            c_OP_LOAD:  w_writes_rd = 1'b1;
            c_OP_BEQ:   w_take = rd_val_q[0];
            c_OP_BNE:   w_take = ~rd_val_q[0];
            default:    ;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= c_ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; waits in FETCH/MEM until memory accepts the request
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:   if (execute) state_d = c_ST_FETCH;
            c_ST_FETCH:  if (mem_ready) state_d = c_ST_DECODE;
            c_ST_DECODE: state_d = c_ST_EXEC;
            c_ST_EXEC: begin
                if (w_op_x == c_OP_HALT)
                    state_d = c_ST_HALT;
                else if (w_op_x == c_OP_LOAD || w_op_x == c_OP_STORE)
                    state_d = c_ST_MEM;
                else
                    state_d = c_ST_WB;
            end
            c_ST_MEM:    if (mem_ready) state_d = c_ST_WB;
            c_ST_WB:     state_d = c_ST_NEXT;
            c_ST_NEXT:   state_d = c_ST_FETCH;
            c_ST_HALT:   state_d = c_ST_HALT;
            default:     state_d = c_ST_IDLE;
        endcase
    end

    // Memory request outputs, decoded from state and latched operands only
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_q)
            c_ST_FETCH: begin
                mem_read    = 1'b1;
                mem_address = pc_q;
            end
            c_ST_MEM: begin
                if (w_op_x == c_OP_LOAD) begin
                    mem_read    = 1'b1;
                    mem_address = MEM_ADDR_SIZE'(rs_val_q);
                end else begin
                    mem_write      = 1'b1;
                    mem_address    = MEM_ADDR_SIZE'(rd_val_q);
                    mem_write_data = rs_val_q;
                end
            end
            default: ;
        endcase
    end

    assign halted = (state_q == c_ST_HALT);
    assign state  = state_q;
    assign opcode = w_op;

    // Datapath: instruction latch, operands, result, register file and PC
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= '0;
            ir_q     <= '0;
            rd_val_q <= '0;
            rs_val_q <= '0;
            result_q <= '0;
            take_q   <= 1'b0;
            for (int i = 0; i < c_NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                c_ST_FETCH:  if (mem_ready) ir_q <= mem_read_data;
                c_ST_DECODE: begin
                    rd_val_q <= regs_q[w_rd];
                    rs_val_q <= regs_q[w_rs];
                end
                c_ST_EXEC: begin
                    result_q <= w_alu;
                    take_q   <= w_take;
                end
                c_ST_MEM:    if (mem_ready && w_op_x == c_OP_LOAD) result_q <= mem_read_data;
                c_ST_WB:     if (w_writes_rd) regs_q[w_rd] <= result_q;
                c_ST_NEXT:   pc_q <= take_q ? (pc_q + w_off) : (pc_q + MEM_ADDR_SIZE'(1));
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_core_hs
// Brief    : Directed bench for cpu_core_hs. Small programs are placed in a
//            bench memory with configurable wait states; register contents
//            are observed through STORE traffic against a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_core_hs;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SHL = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd8, OP_LUI = 4'd10, OP_LI = 4'd11;
    localparam logic [3:0] OP_LOAD = 4'd12, OP_STORE = 4'd13, OP_BEQ = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic        clock = 1'b0;
    logic        reset_n, execute, halted, mem_read, mem_write, mem_ready;
    logic [15:0] mem_address, mem_write_data, mem_read_data;
    logic [3:0]  state, opcode;

    always #5 clock = ~clock;

    cpu_core_hs #(
        .WORD_SIZE(16), .OPCODE_SIZE(4), .REG_ADDR_SIZE(4),
        .IMM_SIZE(8), .MEM_ADDR_SIZE(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .execute(execute), .halted(halted),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .mem_read_data(mem_read_data), .state(state), .opcode(opcode)
    );

    // ---------------- memory model with wait states ----------------
    logic [15:0] mem [0:1023];
    int unsigned ifetch_waits = 0, data_waits = 0;
    int unsigned wctr;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) wctr <= 0;
        else if ((mem_read || mem_write) && !mem_ready) wctr <= wctr + 1;
        else wctr <= 0;
    end

    assign mem_ready     = (mem_read || mem_write) &&
                           (wctr >= ((state == 4'd1) ? ifetch_waits : data_waits));
    assign mem_read_data = mem[mem_address[9:0]];

    // ---------------- bus monitor (sampled on falling edge) ----------------
    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [15:0] fetch_log[$];
    int          mw_cycles = 0;
    bit          unstable = 0, both_hi = 0, prev_mw = 0;
    logic [15:0] prev_a = '0, prev_d = '0, load_addr = '0;

    always @(negedge clock) begin
        if (!reset_n) begin
            obs_q.delete();
            fetch_log.delete();
            mw_cycles = 0;
            unstable  = 0;
            both_hi   = 0;
            prev_mw   = 0;
            load_addr = '0;
        end else begin
            if (mem_read && mem_write) both_hi = 1;
            if (mem_write) begin
                mw_cycles++;
                if (prev_mw && (mem_address != prev_a || mem_write_data != prev_d)) unstable = 1;
            end
            prev_mw = mem_write;
            prev_a  = mem_address;
            prev_d  = mem_write_data;
            if (mem_write && mem_ready) obs_q.push_back('{mem_address, mem_write_data});
            if (mem_read && mem_ready && state == 4'd1) fetch_log.push_back(mem_address);
            if (mem_read && state == 4'd4) load_addr = mem_address;
        end
    end

    // ---------------- checking helpers ----------------
    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] lo);
        return {op, rd, lo};
    endfunction

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs);
        return {op, rd, rs, 4'h0};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back('{a, d});
    endtask

    // Reset, then one execute pulse (or held high). Returns at the first
    // falling edge after execute was sampled, with the core in FETCH.
    task automatic start_run(input bit hold_exec);
        reset_n = 1'b0;
        execute = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        execute = 1'b1;
        @(negedge clock);
        execute = hold_exec;
    endtask

    task automatic run_to_halt(input int bound, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < bound) begin
            @(negedge clock);
            cyc++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check({tag, "_wr_addr"}, 32'(obs_q[i].a), 32'(exp_q[i].a));
                check({tag, "_wr_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
            end
        end
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int n;
        reset_n = 1'b0;
        execute = 1'b0;
        clear_mem();
        repeat (2) @(negedge clock);

        // Reset values
        check("rst_state",  32'(state), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mread",  32'(mem_read), 32'd0);
        check("rst_mwrite", 32'(mem_write), 32'd0);
        check("rst_addr",   32'(mem_address), 32'd0);
        check("rst_wdata",  32'(mem_write_data), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);

        // T1: LI r1,5; ADDI r1,3; HALT with zero waits. Counting the cycle in
        // which execute is sampled as cycle 1, HALT is visible in cycle 15,
        // i.e. 13 falling edges after the first FETCH edge.
        clear_mem();
        mem[0] = ins(OP_LI, 4'd1, 8'd5);
        mem[1] = ins(OP_ADDI, 4'd1, 8'd3);
        mem[2] = ins(OP_HALT, 4'd0, 8'd0);
        ifetch_waits = 0; data_waits = 0;
        start_run(1'b0);
        run_to_halt(100, cyc);
        check("t1_halt_cycle", 32'(cyc), 32'd13);
        check("t1_state", 32'(state), 32'd7);
        check("t1_opcode", 32'(opcode), 32'(OP_HALT));
        check("t1_nfetch", 32'(fetch_log.size()), 32'd3);
        if (fetch_log.size() == 3) check("t1_last_pc", 32'(fetch_log[2]), 32'd2);

        // T2: r1 = 8 stored with 3 wait states; execute held high all run
        clear_mem();
        mem[0] = ins(OP_LI, 4'd1, 8'd5);
        mem[1] = ins(OP_ADDI, 4'd1, 8'd3);
        mem[2] = ins(OP_LI, 4'd2, 8'h20);
        mem[3] = rr(OP_STORE, 4'd2, 4'd1);
        mem[4] = ins(OP_HALT, 4'd0, 8'd0);
        ifetch_waits = 0; data_waits = 3;
        expect_write(16'h0020, 16'h0008);
        start_run(1'b1);
        run_to_halt(200, cyc);
        check("t2_cycles", 32'(cyc), 32'd27);
        check("t2_mw_cycles", 32'(mw_cycles), 32'd4);
        check("t2_stable", 32'(unstable), 32'd0);
        check_writes("t2");
        repeat (5) @(negedge clock);
        execute = 1'b0;
        check("t2_halt_absorb", 32'(state), 32'd7);
        check("t2_no_refetch", 32'(fetch_log.size()), 32'd5);

        // T3: LOAD r2,[r3] with r3=0x40 and 2 waits, then store r2
        clear_mem();
        mem[0] = ins(OP_LI, 4'd3, 8'h40);
        mem[1] = rr(OP_LOAD, 4'd2, 4'd3);
        mem[2] = ins(OP_LI, 4'd5, 8'h30);
        mem[3] = rr(OP_STORE, 4'd5, 4'd2);
        mem[4] = ins(OP_HALT, 4'd0, 8'd0);
        mem[16'h40] = 16'hBEEF;
        ifetch_waits = 0; data_waits = 2;
        expect_write(16'h0030, 16'hBEEF);
        start_run(1'b0);
        run_to_halt(200, cyc);
        check("t3_cycles", 32'(cyc), 32'd29);
        check("t3_load_addr", 32'(load_addr), 32'h0040);
        check("t3_rw_excl", 32'(both_hi), 32'd0);
        check_writes("t3");

        // T4a: BEQ taken (r1=1) at pc=4, imm=3 -> next fetch 7
        clear_mem();
        mem[0] = ins(OP_LI, 4'd1, 8'd1);
        for (int i = 1; i < 4; i++) mem[i] = ins(OP_LI, 4'd6, 8'd0);
        mem[4] = ins(OP_BEQ, 4'd1, 8'd3);
        mem[5] = ins(OP_HALT, 4'd0, 8'd0);
        mem[6] = ins(OP_HALT, 4'd0, 8'd0);
        mem[7] = ins(OP_LI, 4'd7, 8'h77);
        mem[8] = ins(OP_LI, 4'd8, 8'h31);
        mem[9] = rr(OP_STORE, 4'd8, 4'd7);
        mem[10] = ins(OP_HALT, 4'd0, 8'd0);
        data_waits = 0;
        expect_write(16'h0031, 16'h0077);
        start_run(1'b0);
        run_to_halt(200, cyc);
        if (fetch_log.size() > 5) check("t4a_target", 32'(fetch_log[5]), 32'd7);
        else check("t4a_nfetch", 32'(fetch_log.size()), 32'd6);
        check_writes("t4a");

        // T4b: BEQ not taken (r1=0) -> next fetch 5
        mem[0] = ins(OP_LI, 4'd1, 8'd0);
        mem[5] = ins(OP_LI, 4'd7, 8'h55);
        mem[6] = ins(OP_LI, 4'd8, 8'h32);
        mem[7] = rr(OP_STORE, 4'd8, 4'd7);
        mem[8] = ins(OP_HALT, 4'd0, 8'd0);
        expect_write(16'h0032, 16'h0055);
        start_run(1'b0);
        run_to_halt(200, cyc);
        if (fetch_log.size() > 5) check("t4b_target", 32'(fetch_log[5]), 32'd5);
        else check("t4b_nfetch", 32'(fetch_log.size()), 32'd6);
        check_writes("t4b");

        // T4c: BEQ imm=0xFE at pc=4, taken on the first pass (r1=1)
        clear_mem();
        mem[0] = ins(OP_LI, 4'd1, 8'd0);
        mem[1] = ins(OP_LI, 4'd6, 8'd0);
        mem[2] = ins(OP_ADDI, 4'd1, 8'd1);
        mem[3] = ins(OP_LI, 4'd6, 8'd0);
        mem[4] = ins(OP_BEQ, 4'd1, 8'hFE);
        mem[5] = ins(OP_LI, 4'd8, 8'h33);
        mem[6] = rr(OP_STORE, 4'd8, 4'd1);
        mem[7] = ins(OP_HALT, 4'd0, 8'd0);
        mem[258] = ins(OP_HALT, 4'd0, 8'd0);
`ifdef CPU_SIGNED_BRANCH_EN
        expect_write(16'h0033, 16'h0002);
`endif
        start_run(1'b0);
        run_to_halt(300, cyc);
`ifdef CPU_SIGNED_BRANCH_EN
        if (fetch_log.size() > 5) check("t4c_target", 32'(fetch_log[5]), 32'd2);
`else
        if (fetch_log.size() > 5) check("t4c_target", 32'(fetch_log[5]), 32'd258);
`endif
        else check("t4c_nfetch", 32'(fetch_log.size()), 32'd6);
        check_writes("t4c");

        // T5: LUI/LI compose 0xABCD; 0xFFFF+1 wraps to 0; SHL by 1
        clear_mem();
        mem[0]  = ins(OP_LUI, 4'd4, 8'hAB);
        mem[1]  = ins(OP_LI, 4'd4, 8'hCD);
        mem[2]  = ins(OP_LUI, 4'd9, 8'hFF);
        mem[3]  = ins(OP_LI, 4'd9, 8'hFF);
        mem[4]  = ins(OP_LI, 4'd10, 8'd1);
        mem[5]  = rr(OP_ADD, 4'd9, 4'd10);
        mem[6]  = ins(OP_LI, 4'd11, 8'h40);
        mem[7]  = rr(OP_STORE, 4'd11, 4'd4);
        mem[8]  = ins(OP_LI, 4'd11, 8'h41);
        mem[9]  = rr(OP_STORE, 4'd11, 4'd9);
        mem[10] = rr(OP_SHL, 4'd4, 4'd10);
        mem[11] = rr(OP_SUB, 4'd9, 4'd10);
        mem[12] = ins(OP_LI, 4'd11, 8'h42);
        mem[13] = rr(OP_STORE, 4'd11, 4'd4);
        mem[14] = rr(OP_STORE, 4'd11, 4'd9);
        mem[15] = ins(OP_HALT, 4'd0, 8'd0);
        expect_write(16'h0040, 16'hABCD);
        expect_write(16'h0041, 16'h0000);
        expect_write(16'h0042, 16'h579A);
        expect_write(16'h0042, 16'hFFFF);
        start_run(1'b0);
        run_to_halt(400, cyc);
        check_writes("t5");

        // T6: reset during a fetch wait after r4 was written
        clear_mem();
        mem[0] = ins(OP_LI, 4'd4, 8'h5A);
        mem[1] = ins(OP_LI, 4'd12, 8'h50);
        mem[2] = rr(OP_STORE, 4'd12, 4'd4);
        mem[3] = ins(OP_HALT, 4'd0, 8'd0);
        ifetch_waits = 5;
        start_run(1'b0);
        n = 0;
        while (!(fetch_log.size() == 1 && state == 4'd1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("t6_pre_mread", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_mread", 32'(mem_read), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_addr", 32'(mem_address), 32'd0);
        // Fresh run: r4 must read back as zero after the reset
        mem[0] = ins(OP_LI, 4'd12, 8'h50);
        mem[1] = rr(OP_STORE, 4'd12, 4'd4);
        mem[2] = ins(OP_HALT, 4'd0, 8'd0);
        ifetch_waits = 0;
        expect_write(16'h0050, 16'h0000);
        start_run(1'b0);
        run_to_halt(200, cyc);
        check_writes("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
